// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and the transmit FSM state type.
// Used by both the transmit path and the CRC engine.
package eth_pkg;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [10:0] MIN_UDP_PAY   = 11'd18;
    localparam logic [10:0] MAX_UDP_PAY   = 11'd1472;
    localparam logic [10:0] HDR_LAST      = 11'd41;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    // 0x04C11DB7 bit-reversed, for the LSB-first (reflected) CRC-32
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } eth_tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32, one byte per clock; crc is the raw register (invert for the FCS).
// Latency: updated value visible the cycle after enable; no backpressure.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc;
        for (int i = 0; i < 8; i++) begin
            crc_nxt = (crc_nxt[0] ^ data[i]) ? ((crc_nxt >> 1) ^ CRC_POLY_REFL) : (crc_nxt >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc_nxt;
        end
    end
endmodule

// File: rtl/eth_udp_tx.sv
// GMII Ethernet II/IPv4/UDP transmitter: preamble, headers, pulled payload, pad, FCS, IFG.
// First preamble byte the cycle after an accepted start; payload is pulled at line rate with no stall.
module eth_udp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h112233445566,
    parameter logic [47:0] DEST_MAC   = 48'h6c1ff709fa24,
    parameter logic [31:0] LOCAL_IP   = 32'hc0a80180,
    parameter logic [31:0] DEST_IP    = 32'hc0a80141,
    parameter logic [15:0] LOCAL_PORT = 16'd1234,
    parameter logic [15:0] DEST_PORT  = 16'd1234,
    parameter int          IFG_BYTES  = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [15:0] ip_id,
    output logic        data_req,
    input  logic [7:0]  data_in,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en
);
    localparam logic [19:0] CSUM_BASE = 20'h4500 + 20'h4011
        + 20'(LOCAL_IP[31:16]) + 20'(LOCAL_IP[15:0])
        + 20'(DEST_IP[31:16]) + 20'(DEST_IP[15:0]);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [10:0] REQ_SLOT = HDR_LAST - 11'd2;

    eth_tx_state_t state, nxt_state;
    logic [10:0]  cnt, nxt_cnt, len, pad_len, req_left;
    logic [15:0]  id, ip_total, udp_len;
    logic [19:0]  acc;
    logic [31:0]  crc, fcs_word;
    logic [335:0] hdr_vec;
    logic [8:0]   hdr_sh;
    logic [7:0]   nxt_byte;
    logic         start_ok, crc_en;

    assign start_ok = tx_start && !tx_busy && (tx_len != 11'd0) && (tx_len <= MAX_UDP_PAY);
    assign pad_len  = (len < MIN_UDP_PAY) ? (MIN_UDP_PAY - len) : 11'd0;
    assign ip_total = {5'd0, len} + 16'd28;
    assign udp_len  = {5'd0, len} + 16'd8;
    assign fcs_word = ~crc;
    // acc holds the folded ones-complement sum once PRE has run its two fold cycles
    assign hdr_vec  = {DEST_MAC, LOCAL_MAC, ETH_TYPE_IPV4,
                       16'h4500, ip_total, id, 16'h0000, 8'h40, IP_PROTO_UDP, ~acc[15:0],
                       LOCAL_IP, DEST_IP, LOCAL_PORT, DEST_PORT, udp_len, 16'h0000};
    assign hdr_sh   = 9'd328 - {((nxt_state == ST_HDR) ? nxt_cnt[5:0] : 6'd0), 3'b000};
    assign crc_en   = (state != ST_IDLE) &&
                      ((nxt_state == ST_HDR) || (nxt_state == ST_PAY) || (nxt_state == ST_PAD));

    // state/cnt name the byte currently on gmii_txd; nxt_* name the byte being loaded
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 11'd1;
        case (state)
            ST_PRE: if (cnt == 11'd7) begin nxt_state = ST_HDR; nxt_cnt = '0; end
            ST_HDR: if (cnt == HDR_LAST) begin nxt_state = ST_PAY; nxt_cnt = '0; end
            ST_PAY: if (cnt == len - 11'd1) begin
                nxt_state = (pad_len != 11'd0) ? ST_PAD : ST_FCS;
                nxt_cnt   = '0;
            end
            ST_PAD: if (cnt == pad_len - 11'd1) begin nxt_state = ST_FCS; nxt_cnt = '0; end
            ST_FCS: if (cnt == 11'd3) begin nxt_state = ST_IFG; nxt_cnt = '0; end
            ST_IFG: if (cnt == IFG_LAST) begin nxt_state = ST_IDLE; nxt_cnt = '0; end
            default: begin nxt_state = ST_IDLE; nxt_cnt = '0; end
        endcase
    end

    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_state)
            ST_PRE:  nxt_byte = (nxt_cnt == 11'd7) ? SFD : PREAMBLE;
            ST_HDR:  nxt_byte = hdr_vec[hdr_sh +: 8];
            ST_PAY:  nxt_byte = data_in;
            ST_FCS:  nxt_byte = fcs_word[{nxt_cnt[1:0], 3'b000} +: 8];
            default: nxt_byte = 8'h00;
        endcase
    end

    crc32_d8 u_crc (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clear  (start_ok),
        .enable (crc_en),
        .data   (nxt_byte),
        .crc    (crc)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            len        <= '0;
            id         <= '0;
            acc        <= '0;
            req_left   <= '0;
            data_req   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end else if (state == ST_IDLE) begin
            tx_done <= 1'b0;
            if (start_ok) begin
                state      <= ST_PRE;
                cnt        <= '0;
                len        <= tx_len;
                id         <= ip_id;
                acc        <= CSUM_BASE + {9'd0, tx_len} + 20'd28 + {4'd0, ip_id};
                tx_busy    <= 1'b1;
                gmii_tx_en <= 1'b1;
                gmii_txd   <= PREAMBLE;
            end
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            gmii_txd   <= nxt_byte;
            gmii_tx_en <= (nxt_state != ST_IFG) && (nxt_state != ST_IDLE);
            tx_busy    <= (nxt_state != ST_IDLE);
            tx_done    <= (state == ST_FCS) && (nxt_state == ST_IFG);
            if ((state == ST_PRE) && (cnt < 11'd2)) begin
                acc <= {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
            end
            // Request leads the PAY slot by two cycles: one for the upstream read, one for the txd register
            if ((state == ST_HDR) && (cnt == REQ_SLOT)) begin
                data_req <= 1'b1;
                req_left <= len - 11'd1;
            end else if (req_left != 11'd0) begin
                data_req <= 1'b1;
                req_left <= req_left - 11'd1;
            end else begin
                data_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_udp_tx.sv
// Directed frame sequence with random payloads, checked against a byte-level frame model.
`timescale 1ns/1ps
module tb_eth_udp_tx;
    localparam logic [47:0] LOCAL_MAC  = 48'h112233445566;
    localparam logic [47:0] DEST_MAC   = 48'h6c1ff709fa24;
    localparam logic [31:0] LOCAL_IP   = 32'hc0a80180;
    localparam logic [31:0] DEST_IP    = 32'hc0a80141;
    localparam logic [15:0] LOCAL_PORT = 16'd1234;
    localparam logic [15:0] DEST_PORT  = 16'd1234;
    localparam int          IFG        = 12;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [15:0] ip_id;
    logic        data_req;
    logic [7:0]  data_in;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        crc_clear, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_val;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  wire_q[$];
    logic [31:0] fcs_exp;

    eth_udp_tx #(
        .LOCAL_MAC(LOCAL_MAC), .DEST_MAC(DEST_MAC), .LOCAL_IP(LOCAL_IP), .DEST_IP(DEST_IP),
        .LOCAL_PORT(LOCAL_PORT), .DEST_PORT(DEST_PORT), .IFG_BYTES(IFG)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(tx_start), .tx_len(tx_len),
        .ip_id(ip_id), .data_req(data_req), .data_in(data_in), .tx_busy(tx_busy),
        .tx_done(tx_done), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en)
    );

    crc32_d8 crc_u (
        .clk(sys_clk), .rst_n(sys_rst_n), .clear(crc_clear), .enable(crc_en),
        .data(crc_data), .crc(crc_val)
    );

    initial begin
        sys_clk = 1'b0;
        forever #4 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    function automatic logic [15:0] ref_csum(input int len, input int id);
        int w[10];
        int s;
        w = '{'h4500, len + 28, id, 0, 'h4011, 0,
              int'(LOCAL_IP >> 16), int'(LOCAL_IP & 32'hFFFF),
              int'(DEST_IP >> 16), int'(DEST_IP & 32'hFFFF)};
        s = 0;
        foreach (w[i]) s += w[i];
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
        return 16'(~s);
    endfunction

    // CRC over the frame body (everything after the SFD), returned already inverted
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++)
            for (int k = 0; k < 8; k++)
                c = ((c[0] ^ exp_q[i][k]) != 1'b0) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    task automatic build_exp(input int len, input int id);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(DEST_MAC, 6);
        push_be(LOCAL_MAC, 6);
        push_be(48'h0800, 2);
        push_be(48'h4500, 2);
        push_be(48'(len + 28), 2);
        push_be(48'(id), 2);
        push_be(48'h0000, 2);
        push_be(48'h4011, 2);
        push_be(48'(ref_csum(len, id)), 2);
        push_be(48'(LOCAL_IP), 4);
        push_be(48'(DEST_IP), 4);
        push_be(48'(LOCAL_PORT), 2);
        push_be(48'(DEST_PORT), 2);
        push_be(48'(len + 8), 2);
        push_be(48'h0000, 2);
        for (int i = 0; i < len; i++) exp_q.push_back(pay_q[i]);
        for (int i = len; i < 18; i++) exp_q.push_back(8'h00);
        fcs_exp = ref_fcs();
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs_exp[8*k +: 8]);
    endtask

    function automatic logic [7:0] wire_at(input int i);
        return (i < wire_q.size()) ? wire_q[i] : 8'hxx;
    endfunction

    task automatic run_frame(input int len, input int id, input bit seq, input int inj,
                             input int rst_cyc, input string nm);
        int w, pi, bad, en_n, en_runs, en_first, req_n, req_runs, req_first, done_n, done_at, busy_n;
        logic prev_en, prev_req;
        w = 8 + 42 + ((len > 18) ? len : 18) + 4;
        pay_q.delete();
        wire_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(seq ? 8'(i) : 8'($urandom));
        build_exp(len, id);
        {pi, bad, en_n, en_runs, req_n, req_runs, done_n, busy_n} = '0;
        en_first = -1; req_first = -1; done_at = -1;
        prev_en = 1'b0; prev_req = 1'b0;
        @(posedge sys_clk); #1;
        tx_start = 1'b1; tx_len = 11'(len); ip_id = 16'(id);
        for (int c = 0; c < w + IFG + 6; c++) begin
            @(posedge sys_clk); #1;
            tx_start = (c == inj) || (c == w + IFG - 1);
            tx_len   = 11'd64;
            ip_id    = 16'($urandom);
            if (prev_req && (pi < pay_q.size())) begin
                data_in = pay_q[pi];
                pi++;
            end else begin
                data_in = 8'($urandom);
            end
            if (c == rst_cyc) sys_rst_n = 1'b0;
            @(negedge sys_clk);
            if (c == rst_cyc) begin
                chk({nm, "_rst_tx_en"}, 32'(gmii_tx_en), 32'd0);
                chk({nm, "_rst_busy"}, 32'(tx_busy), 32'd0);
                chk({nm, "_rst_req"}, 32'(data_req), 32'd0);
                chk({nm, "_rst_txd"}, 32'(gmii_txd), 32'd0);
                @(posedge sys_clk); #1;
                sys_rst_n = 1'b1;
                tx_start  = 1'b0;
                return;
            end
            if (gmii_tx_en) begin
                wire_q.push_back(gmii_txd);
                en_n++;
                if (!prev_en) en_runs++;
                if (en_first < 0) en_first = c;
            end
            if (data_req) begin
                req_n++;
                if (!prev_req) req_runs++;
                if (req_first < 0) req_first = c;
            end
            if (tx_done) begin
                done_n++;
                done_at = c;
            end
            if (tx_busy) busy_n++;
            prev_en  = gmii_tx_en;
            prev_req = data_req;
        end
        tx_start = 1'b0;
        for (int i = 0; i < w; i++) if (wire_at(i) !== exp_q[i]) bad++;
        chk({nm, "_en_first"}, 32'(en_first), 32'd0);
        chk({nm, "_en_cycles"}, 32'(en_n), 32'(w));
        chk({nm, "_en_runs"}, 32'(en_runs), 32'd1);
        chk({nm, "_bad_bytes"}, 32'(bad), 32'd0);
        chk({nm, "_ip_total"}, 32'({wire_at(24), wire_at(25)}), 32'(len + 28));
        chk({nm, "_hdr_csum"}, 32'({wire_at(32), wire_at(33)}), 32'(ref_csum(len, id)));
        chk({nm, "_udp_len"}, 32'({wire_at(46), wire_at(47)}), 32'(len + 8));
        chk({nm, "_fcs"}, {wire_at(w-1), wire_at(w-2), wire_at(w-3), wire_at(w-4)}, fcs_exp);
        chk({nm, "_req_cycles"}, 32'(req_n), 32'(len));
        chk({nm, "_req_runs"}, 32'(req_runs), 32'd1);
        chk({nm, "_req_first"}, 32'(req_first), 32'd48);
        chk({nm, "_done_count"}, 32'(done_n), 32'd1);
        chk({nm, "_done_at"}, 32'(done_at), 32'(w));
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(w + IFG));
    endtask

    task automatic try_bad(input int len, input string nm);
        int busy_n, en_n, done_n;
        busy_n = 0; en_n = 0; done_n = 0;
        @(posedge sys_clk); #1;
        tx_start = 1'b1; tx_len = 11'(len);
        for (int c = 0; c < 20; c++) begin
            @(posedge sys_clk); #1;
            tx_start = 1'b0;
            @(negedge sys_clk);
            if (tx_busy) busy_n++;
            if (gmii_tx_en) en_n++;
            if (tx_done) done_n++;
        end
        chk({nm, "_busy"}, 32'(busy_n), 32'd0);
        chk({nm, "_tx_en"}, 32'(en_n), 32'd0);
        chk({nm, "_done"}, 32'(done_n), 32'd0);
    endtask

    initial begin
        string msg;
        msg = "123456789";
        sys_rst_n = 1'b0; tx_start = 1'b0; tx_len = '0; ip_id = '0; data_in = '0;
        crc_clear = 1'b0; crc_en = 1'b0; crc_data = '0;
        repeat (3) @(negedge sys_clk);
        chk("reset_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("reset_txd", 32'(gmii_txd), 32'd0);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_req", 32'(data_req), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        @(posedge sys_clk); #1;
        crc_clear = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk); #1;
            crc_clear = 1'b0; crc_en = 1'b1; crc_data = msg[i];
        end
        @(posedge sys_clk); #1;
        crc_en = 1'b0;
        @(negedge sys_clk);
        chk("crc_check_value", ~crc_val, 32'hCBF4_3926);

        run_frame(3, 'h48e3, 1'b1, -1, -1, "f1");
        run_frame(64, 'h48df, 1'b0, -1, -1, "f2");
        run_frame(512, 'h48e2, 1'b0, 200, -1, "f3");
        chk("f3_csum_abdd", 32'({wire_at(32), wire_at(33)}), 32'hABDD);
        try_bad(0, "len0");
        try_bad(1473, "len1473");
        run_frame(17, 'h0101, 1'b0, 30, -1, "len17");
        run_frame(18, 'h0202, 1'b0, -1, -1, "len18");
        run_frame(1, 'hFFFF, 1'b0, -1, -1, "len1");
        run_frame(200, 'h1234, 1'b0, -1, 100, "f5");
        run_frame(64, 'h48e0, 1'b0, -1, -1, "f5_after");
        run_frame(1472, 'h7777, 1'b0, 700, -1, "len1472");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
